// File: rtl/fica_update_sched.sv
// Sequencer for one-unit FastICA weight updates (clear, accumulate, scale, subtract, normalise).
// Optional normalise-ack timeout and norm_err output: define FICA_SCHED_TIMEOUT_EN.
module fica_update_sched #(
    parameter int N_SAMPLES = 256,
    parameter int ADDR_W    = 8,
    parameter int MAX_ITER  = 16,
    parameter int ITER_W    = 5,
    parameter int MUL_LAT   = 1,
    parameter int NORM_TO   = 1023
) (
    input  logic              clk_sch,
    input  logic              rstn_sch,
    input  logic              start,
    input  logic              norm_ack,
    input  logic              conv_flag,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [ADDR_W-1:0] smp_addr,
    output logic              acc_clr,
    output logic              en_acc,
    output logic              en_mul,
    output logic              en_sub,
`ifdef FICA_SCHED_TIMEOUT_EN
    output logic              norm_req,
    output logic              norm_err
`else
    output logic              norm_req
`endif
);

    if (N_SAMPLES < 1 || (64'd1 << ADDR_W) < 64'(N_SAMPLES) ||
        MAX_ITER < 1 || (64'd1 << ITER_W) <= 64'(MAX_ITER) ||
        MUL_LAT < 1 || NORM_TO < 1) begin : g_param_chk
        $error("fica_update_sched: illegal parameter set");
    end

    localparam int WAIT_W = $clog2(MUL_LAT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);

    typedef enum logic [2:0] {
        IDLE, CLR, ACC, MUL, MWAIT, SUB, NORM, FIN
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wcnt;
    logic [ITER_W-1:0] iter_nxt;
    logic              iter_last;

    assign iter_nxt  = iter_cnt + 1'b1;
    assign iter_last = (iter_nxt == ITER_MAX);

`ifdef FICA_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(NORM_TO + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(NORM_TO - 1);
    logic [TO_W-1:0] tcnt;
`endif

    always_ff @(posedge clk_sch or negedge rstn_sch) begin
        if (!rstn_sch) begin
            state     <= IDLE;
            wcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            iter_cnt  <= '0;
            smp_addr  <= '0;
            acc_clr   <= 1'b0;
            en_acc    <= 1'b0;
            en_mul    <= 1'b0;
            en_sub    <= 1'b0;
            norm_req  <= 1'b0;
`ifdef FICA_SCHED_TIMEOUT_EN
            tcnt      <= '0;
            norm_err  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    state     <= CLR;
                    busy      <= 1'b1;
                    acc_clr   <= 1'b1;
                    iter_cnt  <= '0;
                    converged <= 1'b0;
                    smp_addr  <= '0;
`ifdef FICA_SCHED_TIMEOUT_EN
                    norm_err  <= 1'b0;
`endif
                end
                CLR: begin
                    acc_clr  <= 1'b0;
                    en_acc   <= 1'b1;
                    smp_addr <= '0;
                    state    <= ACC;
                end
                ACC: if (smp_addr == LAST_ADDR) begin
                    en_acc   <= 1'b0;
                    en_mul   <= 1'b1;
                    smp_addr <= '0;
                    state    <= MUL;
                end else begin
                    smp_addr <= smp_addr + 1'b1;
                end
                MUL: begin
                    en_mul <= 1'b0;
                    wcnt   <= '0;
                    if (MUL_LAT > 1) begin
                        state <= MWAIT;
                    end else begin
                        en_sub <= 1'b1;
                        state  <= SUB;
                    end
                end
                MWAIT: if (wcnt == WAIT_LAST) begin
                    en_sub <= 1'b1;
                    state  <= SUB;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                SUB: begin
                    en_sub   <= 1'b0;
                    norm_req <= 1'b1;
                    state    <= NORM;
`ifdef FICA_SCHED_TIMEOUT_EN
                    tcnt     <= '0;
`endif
                end
                NORM: begin
                    if (norm_ack) begin
                        norm_req <= 1'b0;
                        if (iter_cnt != ITER_MAX) iter_cnt <= iter_nxt;
                        if (conv_flag || iter_last) begin
                            converged <= conv_flag;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else begin
                            acc_clr <= 1'b1;
                            state   <= CLR;
                        end
                    end
`ifdef FICA_SCHED_TIMEOUT_EN
                    // Give up on a silent normalise unit but still close the run.
                    else if (tcnt == TO_LAST) begin
                        norm_req  <= 1'b0;
                        norm_err  <= 1'b1;
                        converged <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fica_update_sched.sv
// Scoreboard bench for fica_update_sched: expected output events are queued, a monitor pops them.
module tb_fica_update_sched;

    localparam int NS = 4;
    localparam int MI = 3;

    typedef struct {
        int dut;
        int kind;
        int cyc;
        int addr;
        int iter;
        int conv;
    } ev_t;

    ev_t exp_q[$];
    ev_t me;
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  t0 = 0;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    logic s0 = 1'b0, a0 = 1'b0, c0 = 1'b0;
    logic s1 = 1'b0, a1 = 1'b0, c1 = 1'b0;
    logic b0, dn0, cv0, clr0, acc0, mul0, sub0, req0;
    logic b1, dn1, cv1, clr1, acc1, mul1, sub1, req1;
    logic [4:0] it0, it1;
    logic [7:0] ad0, ad1;
    logic [20:0] outs0, outs1;
`ifdef FICA_SCHED_TIMEOUT_EN
    logic err0, err1;
`endif

    assign outs0 = {b0, dn0, cv0, it0, ad0, clr0, acc0, mul0, sub0, req0};
    assign outs1 = {b1, dn1, cv1, it1, ad1, clr1, acc1, mul1, sub1, req1};

    fica_update_sched #(
        .N_SAMPLES(NS), .ADDR_W(8), .MAX_ITER(MI), .ITER_W(5),
        .MUL_LAT(1), .NORM_TO(8)
    ) dut (
        .clk_sch(clk), .rstn_sch(rstn), .start(s0),
        .norm_ack(a0), .conv_flag(c0), .busy(b0), .done(dn0),
        .converged(cv0), .iter_cnt(it0), .smp_addr(ad0),
        .acc_clr(clr0), .en_acc(acc0), .en_mul(mul0),
        .en_sub(sub0),
`ifdef FICA_SCHED_TIMEOUT_EN
        .norm_req(req0), .norm_err(err0)
`else
        .norm_req(req0)
`endif
    );

    fica_update_sched #(
        .N_SAMPLES(NS), .ADDR_W(8), .MAX_ITER(MI), .ITER_W(5),
        .MUL_LAT(3), .NORM_TO(8)
    ) dut3 (
        .clk_sch(clk), .rstn_sch(rstn), .start(s1),
        .norm_ack(a1), .conv_flag(c1), .busy(b1), .done(dn1),
        .converged(cv1), .iter_cnt(it1), .smp_addr(ad1),
        .acc_clr(clr1), .en_acc(acc1), .en_mul(mul1),
        .en_sub(sub1),
`ifdef FICA_SCHED_TIMEOUT_EN
        .norm_req(req1), .norm_err(err1)
`else
        .norm_req(req1)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 clr, 1 acc, 2 mul, 3 sub, 4 req, 5 done
    logic [5:0] mhot;
    int mkind, maddr, miter, mconv;
    bit mok;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                mhot  = {dn0, req0, sub0, mul0, acc0, clr0};
                maddr = int'(ad0);
                miter = int'(it0);
                mconv = int'(cv0);
            end else begin
                mhot  = {dn1, req1, sub1, mul1, acc1, clr1};
                maddr = int'(ad1);
                miter = int'(it1);
                mconv = int'(cv1);
            end
            if (mhot != 6'd0) begin
                n_chk++;
                mkind = -1;
                for (int k = 0; k < 6; k++) if (mhot[k]) mkind = k;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event dut%0d cyc %0d hot %b",
                             d, cyc, mhot);
                end else begin
                    me  = exp_q.pop_front();
                    mok = ($countones(mhot) == 1) && (me.dut == d) &&
                          (me.kind == mkind) && (me.cyc == cyc) &&
                          (me.addr == maddr) &&
                          (me.kind != 5 ||
                           (me.iter == miter && me.conv == mconv));
                    if (!mok) begin
                        n_fail++;
                        $display({"FAIL event: got dut%0d hot %b cyc %0d",
                                  " addr %0d iter %0d conv %0d; want dut%0d",
                                  " kind %0d cyc %0d addr %0d iter %0d conv %0d"},
                                 d, mhot, cyc, maddr, miter, mconv,
                                 me.dut, me.kind, me.cyc, me.addr,
                                 me.iter, me.conv);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic push(input int d, input int k, input int rel,
                        input int a, input int i, input int v);
        ev_t e;
        e.dut  = d;
        e.kind = k;
        e.cyc  = t0 + rel;
        e.addr = a;
        e.iter = i;
        e.conv = v;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int d, input logic st,
                         input logic ak, input logic cf);
        if (d == 0) begin
            s0 = st; a0 = ak; c0 = cf;
        end else begin
            s1 = st; a1 = ak; c1 = cf;
        end
    endtask

    task automatic push_iter(input int d, input int b,
                             input int lat, input int dly);
        push(d, 0, b, 0, 0, 0);
        for (int i = 0; i < NS; i++) push(d, 1, b + 1 + i, i, 0, 0);
        push(d, 2, b + 1 + NS, 0, 0, 0);
        push(d, 3, b + 1 + NS + lat, 0, 0, 0);
        for (int j = 0; j <= dly; j++) push(d, 4, b + 2 + NS + lat + j, 0, 0, 0);
    endtask

    // Iteration length is 3 + NS + lat + dly; ack arrives on the last norm_req cycle.
    task automatic do_run(input int d, input int lat, input int dly,
                          input int conv_at, input bit spur, input bit poke);
        int p, last, fin;
        logic st, ak, cf;
        p    = 3 + NS + lat + dly;
        last = (conv_at >= 0 && conv_at < MI) ? conv_at : MI - 1;
        fin  = 1 + (last + 1) * p;
        @(negedge clk);
        t0 = cyc;
        for (int it = 0; it <= last; it++) push_iter(d, 1 + it * p, lat, dly);
        push(d, 5, fin, 0, last + 1, (conv_at == last) ? 1 : 0);
        for (int k = 0; k <= fin + 1; k++) begin
            if (k > 0) @(negedge clk);
            st = (k == 0) || (poke && k == 3);
            ak = 1'b0;
            cf = 1'b0;
            for (int it = 0; it <= last; it++) begin
                if (k == 1 + it * p + 2 + NS + lat + dly) begin
                    ak = 1'b1;
                    cf = (it == conv_at);
                end
            end
            if (spur && k == 4) begin
                ak = 1'b1;
                cf = 1'b1;
            end
            drive(d, st, ak, cf);
            if (k == fin + 1) chk("busy_after_done", d ? int'(b1) : int'(b0), 0);
        end
        drive(d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outs_dut0", int'(outs0), 0);
        chk("reset_outs_dut1", int'(outs1), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic: converge on first ack.
        do_run(0, 1, 0, 0, 1'b0, 1'b0);
        // Cap: never converges, stops after MI iterations.
        do_run(0, 1, 0, -1, 1'b0, 1'b0);
        // Scale latency of 3.
        do_run(1, 3, 0, 0, 1'b0, 1'b0);
        // Delayed ack, spurious ack in ACC, start while busy.
        do_run(0, 1, 5, 1, 1'b1, 1'b1);

        // Abort mid-accumulation just after addr reaches 2.
        @(negedge clk);
        t0 = cyc;
        push(0, 0, 1, 0, 0, 0);
        push(0, 1, 2, 0, 0, 0);
        push(0, 1, 3, 1, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk("abort_outs", int'(outs0), 0);
        repeat (2) @(negedge clk);
        chk("abort_hold_outs", int'(outs0), 0);
        rstn = 1'b1;
        do_run(0, 1, 0, 0, 1'b0, 1'b0);

`ifdef FICA_SCHED_TIMEOUT_EN
        @(negedge clk);
        t0 = cyc;
        push(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < NS; i++) push(0, 1, 2 + i, i, 0, 0);
        push(0, 2, 6, 0, 0, 0);
        push(0, 3, 7, 0, 0, 0);
        for (int j = 0; j < 8; j++) push(0, 4, 8 + j, 0, 0, 0);
        push(0, 5, 16, 0, 0, 0);
        drive(0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 1'b0);
        end
        chk("norm_err_set", int'(err0), 1);
        chk("timeout_busy", int'(b0), 0);
        do_run(0, 1, 0, 0, 1'b0, 1'b0);
        chk("norm_err_clr", int'(err0), 0);
`endif

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
